// File: rtl/id_exe_ctrl_if.sv
// ID -> EX pipeline bus carrying the registered decode results.
// master: driven by the decode stage (id_exe_ctrl); slave: the execute stage.
// Signals: out_valid, exe_cmd, mem_r_en, mem_w_en, wb_en, imm_sel, imm_ext,
//          src1, src2, dest, br_type, pc_out, illegal.
interface id_exe_ctrl_if #(
  parameter int unsigned RADDR_W = 5
);
  localparam int unsigned XLEN  = 32;
  localparam int unsigned CMD_W = 4;
  localparam int unsigned BR_W  = 2;

  logic               out_valid;
  logic [CMD_W-1:0]   exe_cmd;
  logic               mem_r_en;
  logic               mem_w_en;
  logic               wb_en;
  logic               imm_sel;
  logic [XLEN-1:0]    imm_ext;
  logic [RADDR_W-1:0] src1;
  logic [RADDR_W-1:0] src2;
  logic [RADDR_W-1:0] dest;
  logic [BR_W-1:0]    br_type;
  logic [XLEN-1:0]    pc_out;
  logic               illegal;

  modport master (
    output out_valid, exe_cmd, mem_r_en, mem_w_en, wb_en, imm_sel, imm_ext,
           src1, src2, dest, br_type, pc_out, illegal
  );

  modport slave (
    input out_valid, exe_cmd, mem_r_en, mem_w_en, wb_en, imm_sel, imm_ext,
          src1, src2, dest, br_type, pc_out, illegal
  );
endinterface

// File: rtl/id_exe_ctrl.sv
// Instruction decode stage plus ID/EX pipeline register.
// Ports: clk, rst (sync, active-high); in_valid/instr/pc_in from IF/ID;
//        flush kills the instruction in ID; hazard (combinational) asks IF/ID
//        to hold; ex (id_exe_ctrl_if.master) carries the registered EX fields.
module id_exe_ctrl #(
  parameter bit          FORWARD_EN = 1'b0,
  parameter int unsigned RADDR_W    = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [31:0]   instr,
  input  logic [31:0]   pc_in,
  input  logic          flush,
  output logic          hazard,
  id_exe_ctrl_if.master ex
);
  localparam int unsigned XLEN  = 32;
  localparam int unsigned OP_W  = 6;
  localparam int unsigned CMD_W = 4;
  localparam int unsigned BR_W  = 2;
  localparam int unsigned IMM_W = 16;

  localparam logic [OP_W-1:0] OP_NOP  = 6'b000000;
  localparam logic [OP_W-1:0] OP_ADD  = 6'b000001;
  localparam logic [OP_W-1:0] OP_SUB  = 6'b000011;
  localparam logic [OP_W-1:0] OP_AND  = 6'b000101;
  localparam logic [OP_W-1:0] OP_OR   = 6'b000110;
  localparam logic [OP_W-1:0] OP_NOR  = 6'b000111;
  localparam logic [OP_W-1:0] OP_XOR  = 6'b001000;
  localparam logic [OP_W-1:0] OP_SLL  = 6'b001001;
  localparam logic [OP_W-1:0] OP_SRA  = 6'b001010;
  localparam logic [OP_W-1:0] OP_SRL  = 6'b001011;
  localparam logic [OP_W-1:0] OP_ADDI = 6'b100000;
  localparam logic [OP_W-1:0] OP_SUBI = 6'b100001;
  localparam logic [OP_W-1:0] OP_LD   = 6'b100100;
  localparam logic [OP_W-1:0] OP_ST   = 6'b100101;
  localparam logic [OP_W-1:0] OP_BEZ  = 6'b101000;
  localparam logic [OP_W-1:0] OP_BNE  = 6'b101001;
  localparam logic [OP_W-1:0] OP_JMP  = 6'b101010;

  // Instruction fields
  logic [OP_W-1:0]    op;
  logic [RADDR_W-1:0] rd_f, rs1_f, rs2_f, src2_f;
  assign op    = instr[31:26];
  assign rd_f  = RADDR_W'(instr[25:21]);
  assign rs1_f = RADDR_W'(instr[20:16]);
  assign rs2_f = RADDR_W'(instr[15:11]);

  // Decode results
  logic [CMD_W-1:0] dec_cmd;
  logic [BR_W-1:0]  dec_br;
  logic dec_wb, dec_mr, dec_mw, dec_isel, dec_ill, dec_st, use_s1, use_s2;

  // Registered EX fields and tracking
  logic               out_valid_q, out_valid_d;
  logic [CMD_W-1:0]   exe_cmd_q, exe_cmd_d;
  logic               mem_r_en_q, mem_r_en_d;
  logic               mem_w_en_q, mem_w_en_d;
  logic               wb_en_q, wb_en_d;
  logic               imm_sel_q, imm_sel_d;
  logic [XLEN-1:0]    imm_ext_q, imm_ext_d;
  logic [RADDR_W-1:0] src1_q, src1_d, src2_q, src2_d, dest_q, dest_d;
  logic [BR_W-1:0]    br_type_q, br_type_d;
  logic [XLEN-1:0]    pc_out_q, pc_out_d;
  logic               illegal_q, illegal_d;
  logic [RADDR_W-1:0] mem_dst_q;
  logic               mem_wb_q;

  logic ex_wb, ex_ld, hit1, hit2, raw, issue;

  // Opcode decode; unknown opcodes fall through as NOP with illegal set
  always_comb begin
    dec_cmd  = '0;
    dec_br   = '0;
    dec_wb   = 1'b0;
    dec_mr   = 1'b0;
    dec_mw   = 1'b0;
    dec_isel = 1'b0;
    dec_ill  = 1'b0;
    dec_st   = 1'b0;
    use_s1   = 1'b0;
    use_s2   = 1'b0;
    case (op)
      OP_NOP: ;
      OP_ADD: begin dec_cmd = 4'b0000; dec_wb = 1'b1; use_s1 = 1'b1; use_s2 = 1'b1; end
      OP_SUB: begin dec_cmd = 4'b0010; dec_wb = 1'b1; use_s1 = 1'b1; use_s2 = 1'b1; end
      OP_AND: begin dec_cmd = 4'b0100; dec_wb = 1'b1; use_s1 = 1'b1; use_s2 = 1'b1; end
      OP_OR:  begin dec_cmd = 4'b0101; dec_wb = 1'b1; use_s1 = 1'b1; use_s2 = 1'b1; end
      OP_NOR: begin dec_cmd = 4'b0110; dec_wb = 1'b1; use_s1 = 1'b1; use_s2 = 1'b1; end
      OP_XOR: begin dec_cmd = 4'b0111; dec_wb = 1'b1; use_s1 = 1'b1; use_s2 = 1'b1; end
      OP_SLL: begin dec_cmd = 4'b1000; dec_wb = 1'b1; use_s1 = 1'b1; use_s2 = 1'b1; end
      OP_SRA: begin dec_cmd = 4'b1001; dec_wb = 1'b1; use_s1 = 1'b1; use_s2 = 1'b1; end
      OP_SRL: begin dec_cmd = 4'b1010; dec_wb = 1'b1; use_s1 = 1'b1; use_s2 = 1'b1; end
      OP_ADDI: begin dec_cmd = 4'b0000; dec_wb = 1'b1; dec_isel = 1'b1; use_s1 = 1'b1; end
      OP_SUBI: begin dec_cmd = 4'b0010; dec_wb = 1'b1; dec_isel = 1'b1; use_s1 = 1'b1; end
      OP_LD: begin dec_wb = 1'b1; dec_mr = 1'b1; dec_isel = 1'b1; use_s1 = 1'b1; end
      OP_ST: begin
        dec_mw = 1'b1; dec_isel = 1'b1; dec_st = 1'b1; use_s1 = 1'b1; use_s2 = 1'b1;
      end
      OP_BEZ: begin dec_br = 2'b01; dec_isel = 1'b1; use_s1 = 1'b1; end
      OP_BNE: begin dec_br = 2'b10; dec_isel = 1'b1; use_s1 = 1'b1; use_s2 = 1'b1; end
      OP_JMP: begin dec_br = 2'b11; dec_isel = 1'b1; end
      default: dec_ill = 1'b1;
    endcase
  end

  // Stores read the register named in the rd field as their data operand
  assign src2_f = dec_st ? rd_f : rs2_f;

  // In-flight producers: EX stage is the live register output, MEM a copy of it
  assign ex_wb = out_valid_q & wb_en_q;
  assign ex_ld = out_valid_q & mem_r_en_q;

  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    if (FORWARD_EN) begin
      hit1 = ex_ld && (rs1_f == dest_q);
      hit2 = ex_ld && (src2_f == dest_q);
    end else begin
      hit1 = (ex_wb && (rs1_f == dest_q)) || (mem_wb_q && (rs1_f == mem_dst_q));
      hit2 = (ex_wb && (src2_f == dest_q)) || (mem_wb_q && (src2_f == mem_dst_q));
    end
  end

  assign raw = (use_s1 && (rs1_f != '0) && hit1) || (use_s2 && (src2_f != '0) && hit2);
  // Masked during reset so IF/ID never holds on stale tracking contents
  assign hazard = in_valid & ~flush & ~rst & raw;
  assign issue  = in_valid & ~flush & ~hazard;

  // Next EX contents: decoded instruction on issue, otherwise an all-zero bubble
  always_comb begin
    out_valid_d = 1'b0;
    exe_cmd_d   = '0;
    mem_r_en_d  = 1'b0;
    mem_w_en_d  = 1'b0;
    wb_en_d     = 1'b0;
    imm_sel_d   = 1'b0;
    imm_ext_d   = '0;
    src1_d      = '0;
    src2_d      = '0;
    dest_d      = '0;
    br_type_d   = '0;
    pc_out_d    = '0;
    illegal_d   = 1'b0;
    if (issue) begin
      out_valid_d = 1'b1;
      exe_cmd_d   = dec_cmd;
      mem_r_en_d  = dec_mr;
      mem_w_en_d  = dec_mw;
      wb_en_d     = dec_wb & (rd_f != '0);
      imm_sel_d   = dec_isel;
      imm_ext_d   = {{(XLEN-IMM_W){instr[IMM_W-1]}}, instr[IMM_W-1:0]};
      src1_d      = rs1_f;
      src2_d      = src2_f;
      dest_d      = rd_f;
      br_type_d   = dec_br;
      pc_out_d    = pc_in;
      illegal_d   = dec_ill;
    end
  end

  // ID/EX register and MEM-stage destination tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      exe_cmd_q   <= '0;
      mem_r_en_q  <= 1'b0;
      mem_w_en_q  <= 1'b0;
      wb_en_q     <= 1'b0;
      imm_sel_q   <= 1'b0;
      imm_ext_q   <= '0;
      src1_q      <= '0;
      src2_q      <= '0;
      dest_q      <= '0;
      br_type_q   <= '0;
      pc_out_q    <= '0;
      illegal_q   <= 1'b0;
      mem_dst_q   <= '0;
      mem_wb_q    <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      exe_cmd_q   <= exe_cmd_d;
      mem_r_en_q  <= mem_r_en_d;
      mem_w_en_q  <= mem_w_en_d;
      wb_en_q     <= wb_en_d;
      imm_sel_q   <= imm_sel_d;
      imm_ext_q   <= imm_ext_d;
      src1_q      <= src1_d;
      src2_q      <= src2_d;
      dest_q      <= dest_d;
      br_type_q   <= br_type_d;
      pc_out_q    <= pc_out_d;
      illegal_q   <= illegal_d;
      mem_dst_q   <= dest_q;
      mem_wb_q    <= ex_wb;
    end
  end

  assign ex.out_valid = out_valid_q;
  assign ex.exe_cmd   = exe_cmd_q;
  assign ex.mem_r_en  = mem_r_en_q;
  assign ex.mem_w_en  = mem_w_en_q;
  assign ex.wb_en     = wb_en_q;
  assign ex.imm_sel   = imm_sel_q;
  assign ex.imm_ext   = imm_ext_q;
  assign ex.src1      = src1_q;
  assign ex.src2      = src2_q;
  assign ex.dest      = dest_q;
  assign ex.br_type   = br_type_q;
  assign ex.pc_out    = pc_out_q;
  assign ex.illegal   = illegal_q;
endmodule

// File: tb/tb_id_exe_ctrl.sv
// Bench for id_exe_ctrl: two instances (FORWARD_EN=0 and 1) fed independent
// streams; a reference model predicts hazard and the EX register contents,
// expectations are queued and a monitor compares them against the bus.
module tb_id_exe_ctrl;
  typedef struct packed {
    logic        v;
    logic [3:0]  cmd;
    logic        mr, mw, wb, isel;
    logic [31:0] imm;
    logic [4:0]  s1, s2, d;
    logic [1:0]  br;
    logic [31:0] pc;
    logic        ill;
  } exp_t;

  typedef struct {
    logic        v;
    logic        fl;
    logic [31:0] ins;
    logic [31:0] pc;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inv  [2];
  logic [31:0] ins  [2];
  logic [31:0] pcin [2];
  logic        fl   [2];
  logic        haz  [2];
  exp_t        act  [2];

  id_exe_ctrl_if #(.RADDR_W(5)) bus0 ();
  id_exe_ctrl_if #(.RADDR_W(5)) bus1 ();

  id_exe_ctrl #(.FORWARD_EN(1'b0), .RADDR_W(5)) dut0 (
    .clk(clk), .rst(rst), .in_valid(inv[0]), .instr(ins[0]), .pc_in(pcin[0]),
    .flush(fl[0]), .hazard(haz[0]), .ex(bus0)
  );
  id_exe_ctrl #(.FORWARD_EN(1'b1), .RADDR_W(5)) dut1 (
    .clk(clk), .rst(rst), .in_valid(inv[1]), .instr(ins[1]), .pc_in(pcin[1]),
    .flush(fl[1]), .hazard(haz[1]), .ex(bus1)
  );

  assign act[0] = {bus0.out_valid, bus0.exe_cmd, bus0.mem_r_en, bus0.mem_w_en, bus0.wb_en,
                   bus0.imm_sel, bus0.imm_ext, bus0.src1, bus0.src2, bus0.dest,
                   bus0.br_type, bus0.pc_out, bus0.illegal};
  assign act[1] = {bus1.out_valid, bus1.exe_cmd, bus1.mem_r_en, bus1.mem_w_en, bus1.wb_en,
                   bus1.imm_sel, bus1.imm_ext, bus1.src1, bus1.src2, bus1.dest,
                   bus1.br_type, bus1.pc_out, bus1.illegal};

  always #5 clk = ~clk;

  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t q0[$];
  exp_t q1[$];

  // Reference-model state per mode: pipeline occupancy of EX and MEM
  logic [4:0] m_ex_dst [2];
  logic       m_ex_wb  [2];
  logic       m_ex_ld  [2];
  logic [4:0] m_mem_dst[2];
  logic       m_mem_wb [2];

  ent_t dir[$];
  int   dir_idx [2];
  ent_t cur     [2];
  logic hold    [2];
  logic [31:0] pc_ctr [2];

  logic [5:0] legal_ops [17] = '{6'h00, 6'h01, 6'h03, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09,
                                 6'h0A, 6'h0B, 6'h20, 6'h21, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2A};

  function automatic logic [31:0] mk_r(input logic [5:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2);
    return {op, rd, rs1, rs2, 11'd0};
  endfunction

  function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [15:0] imm);
    return {op, rd, rs1, imm};
  endfunction

  function automatic void add_dir(input logic [31:0] i, input logic f);
    ent_t e;
    e.v = 1'b1; e.fl = f; e.ins = i; e.pc = '0;
    dir.push_back(e);
  endfunction

  // Architectural meaning of one instruction, straight from the opcode table
  function automatic void ref_dec(input logic [31:0] i, input logic [31:0] pc,
                                  output exp_t e, output logic u1, output logic u2);
    logic [5:0] op = i[31:26];
    logic [4:0] rd = i[25:21];
    int kind;   // 0 none, 1 register ALU, 2 immediate ALU, 3 load, 4 store, 5 branch
    e = '0; u1 = 1'b0; u2 = 1'b0; kind = 0;
    e.v = 1'b1; e.imm = {{16{i[15]}}, i[15:0]};
    e.s1 = i[20:16]; e.s2 = i[15:11]; e.d = rd; e.pc = pc;
    case (op)
      6'h00: kind = 0;
      6'h01: begin kind = 1; e.cmd = 4'd0;  end
      6'h03: begin kind = 1; e.cmd = 4'd2;  end
      6'h05: begin kind = 1; e.cmd = 4'd4;  end
      6'h06: begin kind = 1; e.cmd = 4'd5;  end
      6'h07: begin kind = 1; e.cmd = 4'd6;  end
      6'h08: begin kind = 1; e.cmd = 4'd7;  end
      6'h09: begin kind = 1; e.cmd = 4'd8;  end
      6'h0A: begin kind = 1; e.cmd = 4'd9;  end
      6'h0B: begin kind = 1; e.cmd = 4'd10; end
      6'h20: begin kind = 2; e.cmd = 4'd0;  end
      6'h21: begin kind = 2; e.cmd = 4'd2;  end
      6'h24: kind = 3;
      6'h25: kind = 4;
      6'h28: begin kind = 5; e.br = 2'b01; u1 = 1'b1; end
      6'h29: begin kind = 5; e.br = 2'b10; u1 = 1'b1; u2 = 1'b1; end
      6'h2A: begin kind = 5; e.br = 2'b11; end
      default: e.ill = 1'b1;
    endcase
    if (kind >= 1 && kind <= 3) e.wb = (rd != 5'd0);
    if (kind == 1) begin u1 = 1'b1; u2 = 1'b1; end
    if (kind == 2 || kind == 3) begin u1 = 1'b1; e.isel = 1'b1; end
    if (kind == 3) e.mr = 1'b1;
    if (kind == 4) begin e.mw = 1'b1; e.isel = 1'b1; e.s2 = rd; u1 = 1'b1; u2 = 1'b1; end
    if (kind == 5) e.isel = 1'b1;
  endfunction

  task automatic fetch(input int m);
    ent_t e;
    pc_ctr[m] = pc_ctr[m] + 32'd4;
    if (dir_idx[m] < dir.size()) begin
      e = dir[dir_idx[m]];
      dir_idx[m]++;
    end else begin
      logic [5:0] op;
      op = ($urandom_range(0, 19) == 0) ? 6'($urandom) : legal_ops[$urandom_range(0, 16)];
      e.v   = ($urandom_range(0, 99) < 85);
      e.fl  = ($urandom_range(0, 99) < 8);
      e.ins = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), 11'($urandom)};
    end
    e.pc = pc_ctr[m];
    cur[m] = e;
  endtask

  // One model step for mode m: predict hazard, check it, queue the EX contents
  task automatic model_step(input int m);
    exp_t       d, e;
    logic       u1, u2, exp_h, raw;
    logic [4:0] blk[$];
    ref_dec(cur[m].ins, cur[m].pc, d, u1, u2);
    if (m == 0) begin
      if (m_ex_wb[m])  blk.push_back(m_ex_dst[m]);
      if (m_mem_wb[m]) blk.push_back(m_mem_dst[m]);
    end else begin
      if (m_ex_ld[m]) blk.push_back(m_ex_dst[m]);
    end
    raw = 1'b0;
    foreach (blk[k]) begin
      if (u1 && d.s1 != 5'd0 && d.s1 == blk[k]) raw = 1'b1;
      if (u2 && d.s2 != 5'd0 && d.s2 == blk[k]) raw = 1'b1;
    end
    exp_h = !rst && cur[m].v && !cur[m].fl && raw;
    n_chk++;
    if (haz[m] !== exp_h) begin
      n_fail++;
      $display("FAIL hazard%0d t=%0t got=%b exp=%b instr=%h", m, $time, haz[m], exp_h, cur[m].ins);
    end
    e = (rst || !cur[m].v || cur[m].fl || exp_h) ? exp_t'(0) : d;
    if (m == 0) q0.push_back(e); else q1.push_back(e);
    if (rst) begin
      m_ex_dst[m] = '0; m_ex_wb[m] = 1'b0; m_ex_ld[m] = 1'b0;
      m_mem_dst[m] = '0; m_mem_wb[m] = 1'b0;
    end else begin
      m_mem_dst[m] = m_ex_dst[m]; m_mem_wb[m] = m_ex_wb[m];
      m_ex_dst[m] = e.d; m_ex_wb[m] = e.v & e.wb; m_ex_ld[m] = e.v & e.mr;
    end
    hold[m] = rst || exp_h;
  endtask

  task automatic apply(input int m);
    inv[m]  = cur[m].v;
    ins[m]  = cur[m].ins;
    pcin[m] = cur[m].pc;
    fl[m]   = cur[m].fl;
  endtask

  // Monitor: compare EX bus against the queued expectation after each edge
  always @(posedge clk) begin
    exp_t e;
    #2;
    for (int m = 0; m < 2; m++) begin
      if ((m == 0 ? q0.size() : q1.size()) != 0) begin
        e = (m == 0) ? q0.pop_front() : q1.pop_front();
        n_chk++;
        if (act[m] !== e) begin
          n_fail++;
          $display("FAIL exbus%0d t=%0t got=%h exp=%h", m, $time, act[m], e);
        end
      end
    end
  end

  initial begin
    for (int m = 0; m < 2; m++) begin
      dir_idx[m] = 0; hold[m] = 1'b0; pc_ctr[m] = 32'h0000_1000;
      m_ex_dst[m] = '0; m_ex_wb[m] = 1'b0; m_ex_ld[m] = 1'b0;
      m_mem_dst[m] = '0; m_mem_wb[m] = 1'b0;
    end
    // Reset release, then decode sweep
    add_dir(mk_r(6'h01, 5'd3, 5'd1, 5'd2), 1'b0);
    foreach (legal_ops[k]) begin
      if (legal_ops[k][5]) add_dir(mk_i(legal_ops[k], 5'd4, 5'd1, 16'hFFF0), 1'b0);
      else                 add_dir(mk_r(legal_ops[k], 5'd4, 5'd1, 5'd2), 1'b0);
    end
    add_dir(mk_r(6'h3F, 5'd4, 5'd1, 5'd2), 1'b0);
    // RAW on an ALU result
    add_dir(mk_r(6'h01, 5'd5, 5'd1, 5'd2), 1'b0);
    add_dir(mk_r(6'h03, 5'd6, 5'd5, 5'd1), 1'b0);
    // Load-use, then ALU-to-ALU dependency
    add_dir(mk_i(6'h24, 5'd7, 5'd1, 16'h0000), 1'b0);
    add_dir(mk_r(6'h01, 5'd8, 5'd7, 5'd7), 1'b0);
    add_dir(mk_r(6'h01, 5'd10, 5'd1, 5'd2), 1'b0);
    add_dir(mk_r(6'h01, 5'd11, 5'd10, 5'd10), 1'b0);
    // R0 writes never block; flush on a dependent instruction
    add_dir(mk_r(6'h01, 5'd0, 5'd1, 5'd2), 1'b0);
    add_dir(mk_r(6'h01, 5'd3, 5'd0, 5'd0), 1'b0);
    add_dir(mk_r(6'h01, 5'd12, 5'd1, 5'd2), 1'b0);
    add_dir(mk_r(6'h03, 5'd13, 5'd12, 5'd12), 1'b1);
    add_dir(mk_r(6'h03, 5'd14, 5'd12, 5'd12), 1'b0);

    for (int m = 0; m < 2; m++) begin
      fetch(m);
      apply(m);
    end

    for (int cyc = 0; cyc < 700; cyc++) begin
      @(negedge clk);
      rst = (cyc < 2) || (cyc == 400) || (cyc == 401);
      for (int m = 0; m < 2; m++) begin
        if (!hold[m]) fetch(m);
        apply(m);
      end
      #1;
      for (int m = 0; m < 2; m++) model_step(m);
    end

    // Drain with idle inputs
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk);
      rst = 1'b0;
      for (int m = 0; m < 2; m++) begin
        cur[m].v = 1'b0; cur[m].fl = 1'b0;
        apply(m);
      end
      #1;
      for (int m = 0; m < 2; m++) model_step(m);
    end
    repeat (2) @(posedge clk);
    #4;
    n_chk++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_fail++;
      $display("FAIL drain got=%0d/%0d pending exp=0/0", q0.size(), q1.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
